// File: rtl/cc_stream_crypt_if.sv
// Plaintext/ciphertext streaming bus of the ChaCha20 stream engine.
// The slave side is the engine; the master side is the feeding/consuming logic.
interface cc_stream_crypt_if #(
    parameter int LEN_W = 32
);
    logic             start;
    logic [255:0]     key;
    logic [95:0]      non;
    logic [31:0]      cnt0;
    logic [LEN_W-1:0] len;
    logic [511:0]     pt;
    logic             pt_valid;
    logic             pt_ready;
    logic [511:0]     ct;
    logic [63:0]      ct_keep;
    logic             ct_last;
    logic             ct_valid;
    logic             ct_ready;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, key, non, cnt0, len, pt, pt_valid, ct_ready,
        input  pt_ready, ct, ct_keep, ct_last, ct_valid, busy, done, err
    );

    modport slave (
        input  start, key, non, cnt0, len, pt, pt_valid, ct_ready,
        output pt_ready, ct, ct_keep, ct_last, ct_valid, busy, done, err
    );
endinterface

// File: rtl/cc_stream_crypt.sv
// ChaCha20 stream encrypt/decrypt engine with a prefetched keystream FIFO,
// plus the iterative ChaCha20 block function it uses (one round per cycle).
module cc_block (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  non,
    input  logic [31:0]  cnt,
    output logic [511:0] stream,
    output logic         done
);
    logic [31:0] x     [16];
    logic [31:0] init  [16];
    logic [31:0] x_nxt [16];
    logic [31:0] seed  [16];
    logic [4:0]  rnd;
    logic        busy;

    function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    always_comb begin
        seed[0] = 32'h61707865;
        seed[1] = 32'h3320646e;
        seed[2] = 32'h79622d32;
        seed[3] = 32'h6b206574;
        for (int unsigned k = 0; k < 8; k++) seed[4+k] = key[32*k +: 32];
        seed[12] = cnt;
        for (int unsigned k = 0; k < 3; k++) seed[13+k] = non[32*k +: 32];
    end

    // Even rounds work on columns, odd rounds on diagonals.
    always_comb begin
        x_nxt = x;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rnd[0])
                {x_nxt[i], x_nxt[4+i], x_nxt[8+i], x_nxt[12+i]} =
                    qr(x[i], x[4+i], x[8+i], x[12+i]);
            else
                {x_nxt[i], x_nxt[4+((i+1)%4)], x_nxt[8+((i+2)%4)], x_nxt[12+((i+3)%4)]} =
                    qr(x[i], x[4+((i+1)%4)], x[8+((i+2)%4)], x[12+((i+3)%4)]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            rnd    <= '0;
            done   <= 1'b0;
            stream <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                x   <= x_nxt;
                rnd <= rnd + 5'd1;
                if (rnd == 5'd19) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    for (int unsigned k = 0; k < 16; k++)
                        stream[32*k +: 32] <= x_nxt[k] + init[k];
                end
            end else if (start) begin
                x    <= seed;
                init <= seed;
                rnd  <= '0;
                busy <= 1'b1;
            end
        end
    end
endmodule

module cc_stream_crypt #(
    parameter int LEN_W    = 32,
    parameter int KS_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    cc_stream_crypt_if.slave bus
);
    localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int CW = $clog2(KS_DEPTH + 1);
    localparam int BW = LEN_W - 5;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [255:0]     key_q;
    logic [95:0]      non_q;
    logic [31:0]      cnt_q;
    logic [LEN_W-1:0] len_q, rem;
    logic [BW-1:0]    nblk, issued;
    logic             outst;
    logic [511:0]     ks_mem [KS_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    ks_cnt;
    logic             req, blk_done, pt_fire, ct_fire, is_last;
    logic [511:0]     blk_stream, ct_nxt;
    logic [63:0]      mask;

    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
        return (p == PW'(KS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign nblk    = {1'b0, len_q[LEN_W-1:6]} + {{(BW-1){1'b0}}, |len_q[5:0]};
    assign pt_fire = bus.pt_valid && bus.pt_ready;
    assign ct_fire = bus.ct_valid && bus.ct_ready;
    assign is_last = rem <= LEN_W'(64);
    assign req     = (state == RUN) && !outst && (issued < nblk) && (ks_cnt < CW'(KS_DEPTH));

    assign bus.pt_ready = (state == RUN) && (ks_cnt != '0) && (!bus.ct_valid || bus.ct_ready);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

    cc_block u_blk (
        .clk    (clk),
        .rst_n  (~rst),
        .start  (req),
        .key    (key_q),
        .non    (non_q),
        .cnt    (cnt_q),
        .stream (blk_stream),
        .done   (blk_done)
    );

    always_comb begin
        mask = '1;
        if (is_last && len_q[5:0] != 6'd0) mask = (64'd1 << len_q[5:0]) - 64'd1;
        ct_nxt = '0;
        for (int unsigned i = 0; i < 64; i++)
            ct_nxt[8*i +: 8] = mask[i] ? (bus.pt[8*i +: 8] ^ ks_mem[rd_ptr][8*i +: 8]) : 8'h00;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len != '0) ? RUN : DONE;
            RUN:     if (pt_fire && is_last) state_nxt = FLUSH;
            FLUSH:   if (ct_fire && bus.ct_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (blk_done) ks_mem[wr_ptr] <= blk_stream;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q        <= '0;
            non_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            rem          <= '0;
            issued       <= '0;
            outst        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ks_cnt       <= '0;
            bus.ct       <= '0;
            bus.ct_keep  <= '0;
            bus.ct_last  <= 1'b0;
            bus.ct_valid <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                key_q   <= bus.key;
                non_q   <= bus.non;
                cnt_q   <= bus.cnt0;
                len_q   <= bus.len;
                rem     <= bus.len;
                issued  <= '0;
                bus.err <= 1'b0;
            end
            // A wrapped counter only matters if another block still follows it.
            if (req) begin
                cnt_q  <= cnt_q + 32'd1;
                issued <= issued + BW'(1);
                outst  <= 1'b1;
                if (cnt_q == '1 && (issued + BW'(1)) < nblk) bus.err <= 1'b1;
            end
            if (blk_done) begin
                outst  <= 1'b0;
                wr_ptr <= adv(wr_ptr);
            end
            if (pt_fire) begin
                rd_ptr       <= adv(rd_ptr);
                rem          <= rem - LEN_W'(64);
                bus.ct       <= ct_nxt;
                bus.ct_keep  <= mask;
                bus.ct_last  <= is_last;
                bus.ct_valid <= 1'b1;
            end else if (ct_fire) begin
                bus.ct_valid <= 1'b0;
            end
            ks_cnt <= ks_cnt + CW'(blk_done) - CW'(pt_fire);
        end
    end
endmodule
